// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 (double-dabble) binary-to-BCD converter.
// A conversion is accepted in IDLE. It runs WIDTH shift cycles in SHIFT,
// then FINISH publishes the digits together with a one-cycle done pulse.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int SRW = 4*DIGITS + WIDTH;
  localparam int CW  = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0]          r_state;
  logic [SRW-1:0]      r_sr;
  logic [CW-1:0]       r_cnt;
  logic                r_busy;
  logic                r_done;
  logic [4*DIGITS-1:0] r_bcd;

  logic [SRW-1:0]      w_adj;
  logic [SRW-1:0]      w_shift;

  // Add-3 adjustment of every BCD nibble in parallel, followed by the left shift
  always_comb begin
    w_adj = r_sr;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (r_sr[WIDTH + 4*k +: 4] >= 4'd5)
        w_adj[WIDTH + 4*k +: 4] = r_sr[WIDTH + 4*k +: 4] + 4'd3;
    end
    w_shift = w_adj << 1;
  end

  // Control FSM, shift register, counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_bcd   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_sr    <= SRW'(bin);
            r_cnt   <= CW'(WIDTH);
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_sr  <= w_shift;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1))
            r_state <= S_FINISH;
        end
        S_FINISH: begin
          r_bcd   <= r_sr[SRW-1:WIDTH];
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign bcd  = r_bcd;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq (WIDTH=16, DIGITS=5).
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] bin;
  logic        busy;
  logic        done;
  logic [19:0] bcd;

  int n_cmp = 0;
  int n_err = 0;

  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] bin;
    logic [19:0] exp;
  } vec_t;

  // Decimal digits by repeated division
  function automatic logic [19:0] ref_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
    end
  endtask

  // Ticks until done is seen; n = ticks taken, 0 on timeout
  task automatic wait_done(input int limit, output int n);
    n = 0;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // One full conversion from IDLE with latency, busy and pulse checks
  task automatic do_conv(input logic [15:0] v, input logic [19:0] exp, input string tag);
    int lat;
    int bad;
    start = 1'b1;
    bin   = v;
    tick();
    start = 1'b0;
    bin   = 16'($urandom);
    bad   = (busy !== 1'b1) ? 1 : 0;
    lat   = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i <= 16 && busy !== 1'b1) bad++;
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk({tag, "_latency"}, lat, 17);
    chk({tag, "_bcd"}, bcd, exp);
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_busy_profile_errs"}, bad, 0);
    tick();
    chk({tag, "_done_single"}, done, 0);
  endtask

  vec_t vecs[8];

  initial begin
    int lat;
    int lat2;
    int nd;
    logic [19:0] got;
    logic [15:0] r;

    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    tick();
    tick();
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_bcd", bcd, 0);
    rst = 1'b0;
    tick();

    vecs[0] = '{16'd0,     20'h00000};
    vecs[1] = '{16'd12345, 20'h12345};
    vecs[2] = '{16'd65535, 20'h65535};
    vecs[3] = '{16'd1000,  20'h01000};
    vecs[4] = '{16'd9,     20'h00009};
    vecs[5] = '{16'd4096,  20'h04096};
    vecs[6] = '{16'd99,    20'h00099};
    vecs[7] = '{16'd59999, 20'h59999};
    for (int i = 0; i < 8; i++)
      do_conv(vecs[i].bin, vecs[i].exp, $sformatf("vec%0d", i));

    // Randomized values against the division-based reference
    for (int i = 0; i < 30; i++) begin
      r = 16'($urandom);
      do_conv(r, ref_bcd(32'(r)), $sformatf("rand%0d", i));
    end

    // Back-to-back: restart on the cycle done is high
    start = 1'b1;
    bin   = 16'd9;
    tick();
    start = 1'b0;
    wait_done(40, lat);
    chk("b2b_first_latency", lat, 17);
    chk("b2b_first_bcd", bcd, 20'h00009);
    start = 1'b1;
    bin   = 16'd4096;
    tick();
    start = 1'b0;
    chk("b2b_accept_busy", busy, 1);
    wait_done(40, lat2);
    chk("b2b_gap", lat2 + 1, 18);
    chk("b2b_second_bcd", bcd, 20'h04096);
    tick();

    // start held and pulsed while busy, bin changed mid-conversion
    start = 1'b1;
    bin   = 16'd77;
    nd    = 0;
    got   = '0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1) begin
        nd++;
        got = bcd;
      end
      if (i == 5)  bin = 16'd999;
      if (i == 10) start = 1'b0;
      if (i == 12) start = 1'b1;
      if (i == 13) start = 1'b0;
      if (i == 14) start = 1'b1;
      if (i == 15) start = 1'b0;
    end
    chk("held_start_done_count", nd, 1);
    chk("held_start_bcd", got, 20'h00077);

    // Reset during shift 8 aborts the conversion
    do_conv(16'd42, 20'h00042, "pre_reset");
    start = 1'b1;
    bin   = 16'd1234;
    tick();
    start = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_bcd", bcd, 0);
    nd = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done === 1'b1) nd++;
    end
    chk("abort_no_done", nd, 0);
    chk("abort_bcd_held", bcd, 0);
    do_conv(16'd250, 20'h00250, "post_reset");

    // Divider chaining: a one-cycle done pulse with bin = quotient held afterwards
    bin = '0;
    repeat (20) tick();
    bin   = 16'(50000 / 7);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(40, lat);
    chk("chain_latency", lat, 17);
    chk("chain_bcd", bcd, 20'h07142);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
